// File: rtl/pipeline_pkg.sv
// Shared constants and types for the pipeline hazard/forwarding controller.
package pipeline_pkg;

  // Forward-select encodings for the EX-stage operand muxes.
  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_WB      = 2'd1;
  localparam logic [1:0] FWD_MEM     = 2'd2;

  // Countdown width: covers the full MUL/DIV latency range (2..15).
  localparam int MD_CNT_W = 4;

  typedef logic [MD_CNT_W-1:0] md_cnt_t;

  // Scoreboard slot bookkeeping; the destination register is held alongside
  // in a separately parameterised array so RA_W can change per instance.
  typedef struct packed {
    logic    valid;
    md_cnt_t cnt;
  } sb_entry_t;

  // Control-row encoding {PCWrite, IF2ID_write, IF2ID_flush, ID2EX_flush}.
  localparam logic [3:0] CTRL_NORMAL = 4'b1100;
  localparam logic [3:0] CTRL_STALL  = 4'b0001;
  localparam logic [3:0] CTRL_JUMP   = 4'b1010;
  localparam logic [3:0] CTRL_BRANCH = 4'b1011;

endpackage

// File: rtl/md_scoreboard.sv
// Destination-register scoreboard for in-flight MUL/DIV operations.
// Each slot counts down from MD_LAT-1; the slot at zero signals completion
// that cycle and frees itself on the following edge. Fixed latency plus at
// most one issue per cycle keeps completions in issue order, one per cycle.
module md_scoreboard
  import pipeline_pkg::*;
#(
  parameter int RA_W     = 5,
  parameter int MD_LAT   = 4,
  parameter int MD_SLOTS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_i,     // accepted issue (already qualified by stall)
  input  logic [RA_W-1:0] issue_rd_i,
  input  logic [RA_W-1:0] src_a_i,
  input  logic [RA_W-1:0] src_b_i,
  output logic            sb_hit_o,
  output logic            md_done_o,
  output logic [RA_W-1:0] md_done_rd_o,
  output logic            md_full_o
);

  localparam md_cnt_t CNT_INIT = md_cnt_t'(MD_LAT - 1);

  sb_entry_t       ent_q [MD_SLOTS];
  logic [RA_W-1:0] rd_q  [MD_SLOTS];
  logic [MD_SLOTS-1:0] alloc_oh;

  // Slot status decode: fullness, source hits, completion and lowest free slot.
  always_comb begin
    logic found;
    md_full_o    = 1'b1;
    sb_hit_o     = 1'b0;
    md_done_o    = 1'b0;
    md_done_rd_o = '0;
    alloc_oh     = '0;
    found        = 1'b0;
    for (int i = 0; i < MD_SLOTS; i++) begin
      if (!ent_q[i].valid) begin
        md_full_o = 1'b0;
        if (!found) begin
          alloc_oh[i] = 1'b1;
          found       = 1'b1;
        end
      end
      // Register 0 never creates a dependency even though it holds a slot.
      if (ent_q[i].valid && (rd_q[i] != '0) &&
          ((rd_q[i] == src_a_i) || (rd_q[i] == src_b_i))) begin
        sb_hit_o = 1'b1;
      end
      if (ent_q[i].valid && (ent_q[i].cnt == '0)) begin
        md_done_o    = 1'b1;
        md_done_rd_o = rd_q[i];
      end
    end
  end

  // Slot update: allocate on issue, count down, retire at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MD_SLOTS; i++) begin
        ent_q[i] <= '0;
        rd_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < MD_SLOTS; i++) begin
        if (issue_i && alloc_oh[i]) begin
          ent_q[i].valid <= 1'b1;
          ent_q[i].cnt   <= CNT_INIT;
          rd_q[i]        <= issue_rd_i;
        end else if (ent_q[i].valid) begin
          if (ent_q[i].cnt == '0) begin
            ent_q[i].valid <= 1'b0;
          end else begin
            ent_q[i].cnt <= ent_q[i].cnt - 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Forwarding and hazard controller for a 5-stage pipeline with a multi-cycle
// MUL/DIV unit. Produces EX/ID forward selects, load-use and MUL/DIV stalls,
// jump/branch flushes, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int RA_W     = 5,
  parameter int MD_LAT   = 4,
  parameter int MD_SLOTS = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             EX2MEM_RegWrite,
  input  logic             MEM2WB_RegWrite,
  input  logic [RA_W-1:0]  EX2MEM_Rd,
  input  logic [RA_W-1:0]  MEM2WB_Rd,
  input  logic [RA_W-1:0]  ID2EX_Rs,
  input  logic [RA_W-1:0]  ID2EX_Rt,
  input  logic [RA_W-1:0]  IF2ID_Rs,
  input  logic [RA_W-1:0]  IF2ID_Rt,
  input  logic             ID2EX_MemRead,
  input  logic             md_issue,
  input  logic [RA_W-1:0]  md_rd,
  input  logic             Jump,
  input  logic             Branch,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             ForwardC,
  output logic             ForwardD,
  output logic             PCWrite,
  output logic             IF2ID_write,
  output logic             IF2ID_flush,
  output logic             ID2EX_flush,
  output logic             md_done,
  output logic [RA_W-1:0]  md_done_rd,
  output logic             md_full,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             ex_wr_ok;
  logic             wb_wr_ok;
  logic             load_use;
  logic             sb_hit;
  logic             stall;
  logic             md_accept;
  logic [3:0]       ctrl;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  // A stage only forwards when it writes a real (non-zero) register.
  assign ex_wr_ok = EX2MEM_RegWrite && (EX2MEM_Rd != '0);
  assign wb_wr_ok = MEM2WB_RegWrite && (MEM2WB_Rd != '0);

  // EX-stage operand selects: the younger EX/MEM result wins over MEM/WB.
  always_comb begin
    ForwardA = FWD_REGFILE;
    ForwardB = FWD_REGFILE;
    if (ex_wr_ok && (EX2MEM_Rd == ID2EX_Rs)) begin
      ForwardA = FWD_MEM;
    end else if (wb_wr_ok && (MEM2WB_Rd == ID2EX_Rs)) begin
      ForwardA = FWD_WB;
    end
    if (ex_wr_ok && (EX2MEM_Rd == ID2EX_Rt)) begin
      ForwardB = FWD_MEM;
    end else if (wb_wr_ok && (MEM2WB_Rd == ID2EX_Rt)) begin
      ForwardB = FWD_WB;
    end
  end

  // ID-stage read ports bypass the register file on a same-cycle writeback.
  assign ForwardC = wb_wr_ok && (MEM2WB_Rd == IF2ID_Rs);
  assign ForwardD = wb_wr_ok && (MEM2WB_Rd == IF2ID_Rt);

  // A load in EX whose target is read by the instruction in ID.
  assign load_use = ID2EX_MemRead && (ID2EX_Rt != '0) &&
                    ((ID2EX_Rt == IF2ID_Rs) || (ID2EX_Rt == IF2ID_Rt));

  // A full scoreboard cannot take another MUL/DIV, so that issue stalls too.
  assign stall     = load_use || sb_hit || (md_full && md_issue);
  assign md_accept = md_issue && !stall;

  md_scoreboard #(
    .RA_W     (RA_W),
    .MD_LAT   (MD_LAT),
    .MD_SLOTS (MD_SLOTS)
  ) u_md_scoreboard (
    .clk          (clk),
    .rst_n        (reset),
    .issue_i      (md_accept),
    .issue_rd_i   (md_rd),
    .src_a_i      (IF2ID_Rs),
    .src_b_i      (IF2ID_Rt),
    .sb_hit_o     (sb_hit),
    .md_done_o    (md_done),
    .md_done_rd_o (md_done_rd),
    .md_full_o    (md_full)
  );

  // Pipeline control rows; a taken branch overrides a stall because the
  // stalled instruction sits on the wrong path and is flushed anyway.
  always_comb begin
    ctrl = CTRL_NORMAL;
    if (Branch && stall) begin
      ctrl = CTRL_BRANCH;
    end else if (stall) begin
      ctrl = CTRL_STALL;
    end else if (Jump) begin
      ctrl = CTRL_JUMP;
    end else if (Branch) begin
      ctrl = CTRL_BRANCH;
    end
  end

  assign {PCWrite, IF2ID_write, IF2ID_flush, ID2EX_flush} = ctrl;

  // Saturating increment of the stall-cycle counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Stall-cycle performance counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
